// File: rtl/axi_bresp_scheduler.sv
// Out-of-order AXI write-response scheduler: buffers {id, resp} completion records and releases
// them one at a time on the B channel in LFSR or age order, keeping same-ID responses in arrival order.
module axi_bresp_scheduler #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ID_W      = 2,
    parameter int unsigned THRESH    = 5,
    parameter int unsigned TIMEOUT   = 100,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmp_valid,
    output logic                   cmp_ready,
    input  logic [ID_W-1:0]        cmp_id,
    input  logic [1:0]             cmp_resp,
    input  logic                   cfg_in_order,
    output logic                   bvalid,
    input  logic                   bready,
    output logic [ID_W-1:0]        bid,
    output logic [1:0]             bresp,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C  = CW'(THRESH);
    localparam logic [WW-1:0] TIMEOUT_C = WW'(TIMEOUT);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;   // older_q[j][i]: slot j arrived before slot i
    logic [ID_W-1:0]             id_q   [DEPTH];
    logic [1:0]                  resp_q [DEPTH];
    logic [CW-1:0]               count_q, count_d;
    logic [WW-1:0]               wait_q, wait_d;
    logic                        bvalid_q, bvalid_d;
    logic [ID_W-1:0]             bid_q, bid_d;
    logic [1:0]                  bresp_q, bresp_d;
    logic [15:0]                 lfsr_q, lfsr_d;

    logic [DEPTH-1:0] elig, oldest;
    logic [IW-1:0]    free_idx, ord_sel, rnd_sel, sel, cand;
    logic             rnd_found, free_found;
    logic             ins, fire, load;

    // A slot is eligible when no older valid slot carries the same ID.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = valid_q[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (valid_q[j] && older_q[j][i] && id_q[j] == id_q[i]) elig[i] = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            oldest[i] = elig[i];
            for (int k = 0; k < DEPTH; k++) begin
                if (k != i && elig[k] && !older_q[i][k]) oldest[i] = 1'b0;
            end
        end
    end

    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    always_comb begin
        ord_sel    = '0;
        rnd_sel    = '0;
        rnd_found  = 1'b0;
        free_idx   = '0;
        free_found = 1'b0;
        cand       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (oldest[i]) ord_sel = IW'(i);
        end
        for (int o = 0; o < DEPTH; o++) begin
            cand = lfsr_q[IW-1:0] + IW'(o);
            if (!rnd_found && elig[cand]) begin
                rnd_found = 1'b1;
                rnd_sel   = cand;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    assign cmp_ready = (count_q < DEPTH_C);
    assign ins       = cmp_valid && cmp_ready;
    assign fire      = (count_q > THRESH_C) || (count_q != '0 && wait_q == TIMEOUT_C);
    assign load      = fire && (|elig) && (!bvalid_q || bready);
    assign sel       = cfg_in_order ? ord_sel : rnd_sel;

    always_comb begin
        valid_d  = valid_q;
        older_d  = older_q;
        count_d  = count_q;
        wait_d   = wait_q;
        bvalid_d = bvalid_q;
        bid_d    = bid_q;
        bresp_d  = bresp_q;
        lfsr_d   = lfsr_q;
        if (load) begin
            valid_d[sel] = 1'b0;
            older_d[sel] = '0;
            for (int k = 0; k < DEPTH; k++) older_d[k][sel] = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q[sel];
            bresp_d  = resp_q[sel];
            lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end else if (bready) begin
            bvalid_d = 1'b0;
        end
        // The new record is younger than everything still valid after this cycle's load.
        if (ins) begin
            for (int j = 0; j < DEPTH; j++) older_d[j][free_idx] = valid_d[j];
            older_d[free_idx]  = '0;
            valid_d[free_idx]  = 1'b1;
        end
        case ({ins, load})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (load || count_q == '0) wait_d = '0;
        else if (wait_q != TIMEOUT_C) wait_d = wait_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= '0;
            older_q  <= '0;
            count_q  <= '0;
            wait_q   <= '0;
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= '0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            valid_q  <= valid_d;
            older_q  <= older_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            bvalid_q <= bvalid_d;
            bid_q    <= bid_d;
            bresp_q  <= bresp_d;
            lfsr_q   <= lfsr_d;
        end
    end

    // NOTE: payload storage is not reset; valid_q alone decides whether a slot's contents matter.
    always_ff @(posedge clk) begin
        if (ins) begin
            id_q[free_idx]   <= cmp_id;
            resp_q[free_idx] <= cmp_resp;
        end
    end

    assign bvalid = bvalid_q;
    assign bid    = bid_q;
    assign bresp  = bresp_q;
    assign count  = count_q;

endmodule

// File: tb/tb_axi_bresp_scheduler.sv
// Bench for axi_bresp_scheduler: directed scenarios plus random traffic, every cycle compared
// against a slot/sequence-number reference model of the scheduling rules.
module tb_axi_bresp_scheduler;
    localparam int DEPTH   = 8;
    localparam int ID_W    = 2;
    localparam int THRESH  = 5;
    localparam int TIMEOUT = 100;
    localparam logic [15:0] SEED = 16'hACE1;

    logic            clk;
    logic            rst_n;
    logic            cmp_valid;
    logic            cmp_ready;
    logic [ID_W-1:0] cmp_id;
    logic [1:0]      cmp_resp;
    logic            cfg_in_order;
    logic            bvalid;
    logic            bready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic [3:0]      count;

    int n_checks = 0;
    int n_fail   = 0;

    axi_bresp_scheduler #(
        .DEPTH(DEPTH), .ID_W(ID_W), .THRESH(THRESH), .TIMEOUT(TIMEOUT), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmp_valid(cmp_valid), .cmp_ready(cmp_ready),
        .cmp_id(cmp_id), .cmp_resp(cmp_resp), .cfg_in_order(cfg_in_order),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: slots with arrival sequence numbers; age = smaller sequence number.
    bit          m_valid [DEPTH];
    int          m_id    [DEPTH];
    int          m_resp  [DEPTH];
    int unsigned m_seq   [DEPTH];
    int unsigned seq_ctr = 0;
    int          m_wait  = 0;
    bit          m_bvalid = 0;
    int          m_bid = 0, m_bresp = 0;
    logic [15:0] m_lfsr = SEED;

    int beat_id[$];
    int beat_resp[$];

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    function automatic int find_beat(input int id, input int resp);
        for (int i = 0; i < beat_id.size(); i++)
            if (beat_id[i] == id && beat_resp[i] == resp) return i;
        return -1;
    endfunction

    task automatic model_step();
        bit elig [DEPTH];
        bit any, fire, ins, load, fb;
        int sel, fidx, cnt, idx;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
            m_wait = 0; m_bvalid = 0; m_bid = 0; m_bresp = 0; m_lfsr = SEED;
            return;
        end
        cnt  = pending();
        ins  = cmp_valid && (cnt < DEPTH);
        fire = (cnt > THRESH) || (cnt != 0 && m_wait == TIMEOUT);
        any  = 0;
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = m_valid[i];
            for (int j = 0; j < DEPTH; j++)
                if (m_valid[j] && m_id[j] == m_id[i] && m_seq[j] < m_seq[i]) elig[i] = 0;
            any |= elig[i];
        end
        load = fire && any && (!m_bvalid || bready);
        sel = -1;
        if (load) begin
            if (cfg_in_order) begin
                for (int i = 0; i < DEPTH; i++)
                    if (elig[i] && (sel < 0 || m_seq[i] < m_seq[sel])) sel = i;
            end else begin
                for (int o = 0; o < DEPTH; o++) begin
                    idx = (int'(m_lfsr) % DEPTH + o) % DEPTH;
                    if (sel < 0 && elig[idx]) sel = idx;
                end
            end
        end
        fidx = -1;
        for (int i = 0; i < DEPTH; i++) if (!m_valid[i] && fidx < 0) fidx = i;
        if (load || cnt == 0) m_wait = 0;
        else if (m_wait < TIMEOUT) m_wait++;
        if (load) begin
            m_bvalid = 1; m_bid = m_id[sel]; m_bresp = m_resp[sel]; m_valid[sel] = 0;
            fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
            m_lfsr = (m_lfsr >> 1) | (16'(fb) << 15);
        end else if (bready) begin
            m_bvalid = 0;
        end
        if (ins) begin
            m_valid[fidx] = 1; m_id[fidx] = int'(cmp_id); m_resp[fidx] = int'(cmp_resp);
            m_seq[fidx] = seq_ctr; seq_ctr++;
        end
    endtask

    // One clock: log any accepted beat, advance the model, then compare 1 time unit after the edge.
    task automatic cycle();
        if (rst_n && bvalid && bready) begin
            beat_id.push_back(int'(bid));
            beat_resp.push_back(int'(bresp));
        end
        model_step();
        @(posedge clk);
        #1;
        check("bvalid", 32'(bvalid), 32'(m_bvalid));
        check("count", 32'(count), pending());
        check("cmp_ready", 32'(cmp_ready), 32'(pending() < DEPTH));
        check("bid", 32'(bid), m_bid);
        check("bresp", 32'(bresp), m_bresp);
    endtask

    int ids2[6]   = '{0, 1, 2, 3, 0, 1};
    int resps2[6] = '{0, 1, 2, 3, 3, 2};
    int ids5[6]   = '{3, 1, 2, 0, 3, 2};
    int n, stale, hold_bid, hold_bresp;

    initial begin
        rst_n = 0; cmp_valid = 1; cmp_id = 2'd1; cmp_resp = 2'd1; cfg_in_order = 0; bready = 0;

        // T1: reset held with cmp_valid asserted
        repeat (3) begin
            cycle();
            check("t1_bvalid", 32'(bvalid), 0);
            check("t1_count", 32'(count), 0);
            check("t1_cmp_ready", 32'(cmp_ready), 1);
        end
        rst_n = 1; cmp_valid = 0;
        cycle();

        // T2: threshold fire, per-ID ordering
        bready = 1; beat_id.delete(); beat_resp.delete();
        for (int k = 0; k < 6; k++) begin
            cmp_valid = 1; cmp_id = ID_W'(ids2[k]); cmp_resp = 2'(resps2[k]);
            cycle();
        end
        cmp_valid = 0;
        check("t2_bvalid_after_1", 32'(bvalid), 0);
        cycle();
        check("t2_bvalid_after_2", 32'(bvalid), 1);
        n = 0;
        while (beat_id.size() < 6 && n < 1500) begin cycle(); n++; end
        check("t2_beats", beat_id.size(), 6);
        check("t2_id0_order", 32'(find_beat(0, 0) >= 0 && find_beat(0, 3) > find_beat(0, 0)), 1);
        check("t2_id1_order", 32'(find_beat(1, 1) >= 0 && find_beat(1, 2) > find_beat(1, 1)), 1);
        check("t2_id2_seen", 32'(find_beat(2, 2) >= 0), 1);
        check("t2_id3_seen", 32'(find_beat(3, 3) >= 0), 1);
        repeat (2) cycle();

        // T3: timeout fire of a single record
        cmp_valid = 1; cmp_id = 2'd2; cmp_resp = 2'b10;
        cycle();
        cmp_valid = 0; n = 1;
        while (!bvalid && n < 300) begin cycle(); n++; end
        check("t3_latency", n, TIMEOUT + 2);
        check("t3_bid", 32'(bid), 2);
        check("t3_bresp", 32'(bresp), 2);
        repeat (2) cycle();

        // T4: backpressure with a full buffer
        bready = 0; cmp_valid = 1; n = 0;
        while (cmp_ready && n < 50) begin
            cmp_id = ID_W'($urandom); cmp_resp = 2'($urandom);
            cycle(); n++;
        end
        cmp_valid = 0;
        check("t4_cmp_ready", 32'(cmp_ready), 0);
        check("t4_count_full", 32'(count), DEPTH);
        check("t4_bvalid", 32'(bvalid), 1);
        hold_bid = int'(bid); hold_bresp = int'(bresp);
        repeat (5) cycle();
        check("t4_bid_stable", 32'(bid), hold_bid);
        check("t4_bresp_stable", 32'(bresp), hold_bresp);
        check("t4_bvalid_stable", 32'(bvalid), 1);
        beat_id.delete(); beat_resp.delete();
        bready = 1; cycle(); bready = 0;
        repeat (3) cycle();
        check("t4_one_beat", beat_id.size(), 1);
        check("t4_beat_bid", beat_id.size() > 0 ? beat_id[0] : -1, hold_bid);
        check("t4_count_after", 32'(count), DEPTH - 1);
        bready = 1; n = 0;
        while ((count != 0 || bvalid) && n < 1500) begin cycle(); n++; end
        check("t4_drained", 32'(count), 0);

        // T5: in-order mode
        cfg_in_order = 1; beat_id.delete(); beat_resp.delete();
        for (int k = 0; k < 6; k++) begin
            cmp_valid = 1; cmp_id = ID_W'(ids5[k]); cmp_resp = 2'($urandom);
            cycle();
        end
        cmp_valid = 0; n = 0;
        while (beat_id.size() < 6 && n < 1500) begin cycle(); n++; end
        check("t5_beats", beat_id.size(), 6);
        for (int k = 0; k < beat_id.size() && k < 6; k++)
            check($sformatf("t5_bid%0d", k), beat_id[k], ids5[k]);
        repeat (2) cycle();

        // T6: reset while a beat is stalled
        cfg_in_order = 0; bready = 0;
        for (int k = 0; k < 5; k++) begin
            cmp_valid = 1; cmp_id = ID_W'($urandom); cmp_resp = 2'($urandom);
            cycle();
        end
        cmp_valid = 0; n = 0;
        while (!bvalid && n < 300) begin cycle(); n++; end
        check("t6_bvalid_pre", 32'(bvalid), 1);
        check("t6_count_pre", 32'(count), 4);
        rst_n = 0; cycle(); rst_n = 1;
        check("t6_bvalid_rst", 32'(bvalid), 0);
        check("t6_count_rst", 32'(count), 0);
        bready = 1; stale = 0; beat_id.delete(); beat_resp.delete();
        repeat (300) begin cycle(); if (bvalid) stale++; end
        check("t6_no_stale", stale, 0);
        check("t6_no_beats", beat_id.size(), 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) cfg_in_order = 1'($urandom);
            rst_n     = ($urandom % 997) != 0;
            cmp_valid = ($urandom % 4) != 0;
            cmp_id    = ID_W'($urandom);
            cmp_resp  = 2'($urandom);
            bready    = ($urandom % 3) != 0;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
